// File: rtl/pll_ctrl_pkg.sv
// Shared definitions for the PLL reset sequencing logic.
//   pll_state_t : sequencer states, the encoding is visible on state_o
//   DEF_*       : default timing constants for a 50 MHz refclk
//   max3        : helper used to size the shared cycle counter
package pll_ctrl_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } pll_state_t;

  localparam int DEF_RST_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT  = 50000;  // 1 ms at 50 MHz
  localparam int DEF_STABLE_CYCLES = 1024;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous status bit.
//   clk : destination clock
//   rst : synchronous active-high reset, clears both flops
//   d   : asynchronous input
//   q   : synchronized output, follows d two edges later
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Sequences the UART reference PLL out of reset and gates downstream reset
// on a stable lock. Re-resets the PLL on lock timeout or loss of lock.
//   refclk      : 50 MHz board clock, everything runs on its rising edge
//   rst         : synchronous active-high reset
//   pll_locked  : PLL lock indication, asynchronous to refclk
//   pll_rst     : active-high reset to the PLL
//   sys_rst     : active-high reset request for downstream logic
//   ready       : PLL output valid and stable (always ~sys_rst)
//   state_o     : current state for debug
//   timeout_cnt : saturating count of lock timeouts
//   lol_cnt     : saturating count of loss-of-lock events while running
//
// state     | meaning
// ----------+------------------------------------------------------------
// PLL_RST   | PLL held in reset for RST_CYCLES cycles
// WAIT_LOCK | PLL released, waiting up to LOCK_TIMEOUT cycles for lock
// STABLE    | lock seen, must hold for STABLE_CYCLES before release
// RUN       | downstream released; any lock drop re-resets the PLL
module pll_reset_sequencer
  import pll_ctrl_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int CNT_W         = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             pll_locked,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             ready,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] timeout_cnt,
  output logic [CNT_W-1:0] lol_cnt
);

  // One counter serves all three timed states; size it for the longest.
  localparam int CW = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES));

  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);

  pll_state_t    state;
  logic [CW-1:0] cnt;
  logic          lk_s;

  sync_2ff u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lk_s)
  );

  assign state_o = state;

  always_ff @(posedge refclk) begin
    if (rst) begin
      state       <= PLL_RST;
      cnt         <= '0;
      pll_rst     <= 1'b1;
      sys_rst     <= 1'b1;
      ready       <= 1'b0;
      timeout_cnt <= '0;
      lol_cnt     <= '0;
    end else begin
      case (state)
        PLL_RST: begin
          if (cnt == RST_LAST) begin
            state   <= WAIT_LOCK;
            cnt     <= '0;
            pll_rst <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        WAIT_LOCK: begin
          if (lk_s) begin
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt == LOCK_LAST) begin
            state   <= PLL_RST;
            cnt     <= '0;
            pll_rst <= 1'b1;
            if (timeout_cnt != '1) timeout_cnt <= timeout_cnt + CNT_W'(1);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        STABLE: begin
          // A dropout here is treated as chatter: retry without counting.
          if (!lk_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STABLE_LAST) begin
            state   <= RUN;
            cnt     <= '0;
            sys_rst <= 1'b0;
            ready   <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        RUN: begin
          if (!lk_s) begin
            state   <= PLL_RST;
            cnt     <= '0;
            pll_rst <= 1'b1;
            sys_rst <= 1'b1;
            ready   <= 1'b0;
            if (lol_cnt != '1) lol_cnt <= lol_cnt + CNT_W'(1);
          end
        end

        default: begin
          state   <= PLL_RST;
          cnt     <= '0;
          pll_rst <= 1'b1;
          sys_rst <= 1'b1;
          ready   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench: stimulus pushes each expected output change with the
// refclk cycle it must appear on; a monitor pops and compares whenever the
// DUT output vector changes, and checks the output invariants every cycle.
module tb_pll_reset_sequencer;

  localparam int RST = 4;
  localparam int LT  = 20;
  localparam int SC  = 8;

  logic       refclk;
  logic       rst;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic [1:0] state_o;
  logic [7:0] timeout_cnt;
  logic [7:0] lol_cnt;

  pll_reset_sequencer #(
    .RST_CYCLES    (RST),
    .LOCK_TIMEOUT  (LT),
    .STABLE_CYCLES (SC),
    .CNT_W         (8)
  ) dut (
    .refclk      (refclk),
    .rst         (rst),
    .pll_locked  (pll_locked),
    .pll_rst     (pll_rst),
    .sys_rst     (sys_rst),
    .ready       (ready),
    .state_o     (state_o),
    .timeout_cnt (timeout_cnt),
    .lol_cnt     (lol_cnt)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  int cyc = 0;
  always @(posedge refclk) cyc = cyc + 1;

  typedef struct {
    int          c;
    logic [20:0] v;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic expect_at(input int c, input logic [1:0] st, input logic p,
                           input logic s, input logic r, input int tc, input int lc);
    exp_t e;
    e.c = c;
    e.v = {st, p, s, r, 8'(tc), 8'(lc)};
    q.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge refclk);
  endtask

  // Monitor
  logic [20:0] prev = 'x;
  logic [20:0] obs;
  exp_t        e_pop;
  always @(negedge refclk) begin
    if (cyc >= 1) begin
      obs = {state_o, pll_rst, sys_rst, ready, timeout_cnt, lol_cnt};
      n_chk++;
      if (ready !== ~sys_rst) begin
        n_fail++;
        $display("FAIL ready_vs_sys_rst cyc=%0d ready=%b sys_rst=%b", cyc, ready, sys_rst);
      end
      n_chk++;
      if (pll_rst === 1'b1 && ready === 1'b1) begin
        n_fail++;
        $display("FAIL pll_rst_and_ready cyc=%0d both high", cyc);
      end
      if (obs !== prev) begin
        prev = obs;
        n_chk++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change cyc=%0d got=%h", cyc, obs);
        end else begin
          e_pop = q.pop_front();
          if (e_pop.c != cyc || e_pop.v !== obs) begin
            n_fail++;
            $display("FAIL transition got cyc=%0d {st,prst,srst,rdy,tcnt,lcnt}=%h required cyc=%0d val=%h",
                     cyc, obs, e_pop.c, e_pop.v);
          end
        end
      end
    end
  end

  int w, s, u, p, c6;

  initial begin
    rst        = 1'b1;
    pll_locked = 1'b0;

    // 1: reset for 3 cycles, then pll_rst for 4 cycles, then wait for lock
    expect_at(1, 2'd0, 1, 1, 0, 0, 0);
    wait_until(3);
    rst = 1'b0;
    w = 3 + RST;
    expect_at(w, 2'd1, 0, 1, 0, 0, 0);

    // 3: no lock -> repeated timeouts, counter saturates at 255
    for (int i = 1; i <= 300; i++) begin
      expect_at(w + LT,       2'd0, 1, 1, 0, (i > 255) ? 255 : i, 0);
      expect_at(w + LT + RST, 2'd1, 0, 1, 0, (i > 255) ? 255 : i, 0);
      w = w + LT + RST;
    end

    // 2: lock rises 5 cycles into WAIT_LOCK
    wait_until(w + 5);
    pll_locked = 1'b1;
    s = w + 8;
    expect_at(s,      2'd2, 0, 1, 0, 255, 0);
    expect_at(s + SC, 2'd3, 0, 0, 1, 255, 0);
    u = s + SC;

    // 5: three loss-of-lock events; 4: chatter in STABLE on the first relock
    for (int k = 1; k <= 3; k++) begin
      wait_until(u + 3);
      pll_locked = 1'b0;
      p = u + 6;
      expect_at(p, 2'd0, 1, 1, 0, 255, k);
      w = p + RST;
      expect_at(w, 2'd1, 0, 1, 0, 255, k);
      wait_until(w + 2);
      pll_locked = 1'b1;
      s = w + 5;
      expect_at(s, 2'd2, 0, 1, 0, 255, k);
      if (k == 1) begin
        wait_until(s + 4);
        pll_locked = 1'b0;
        wait_until(s + 5);
        pll_locked = 1'b1;
        expect_at(s + 7, 2'd1, 0, 1, 0, 255, k);
        s = s + 8;
        expect_at(s, 2'd2, 0, 1, 0, 255, k);
      end
      expect_at(s + SC, 2'd3, 0, 0, 1, 255, k);
      u = s + SC;
    end

    // 6: one-cycle rst while running with lol_cnt=3
    wait_until(u + 4);
    rst = 1'b1;
    c6 = u + 5;
    expect_at(c6, 2'd0, 1, 1, 0, 0, 0);
    wait_until(c6);
    rst = 1'b0;
    w = c6 + RST;
    expect_at(w,          2'd1, 0, 1, 0, 0, 0);
    expect_at(w + 1,      2'd2, 0, 1, 0, 0, 0);
    expect_at(w + 1 + SC, 2'd3, 0, 0, 1, 0, 0);

    wait_until(w + 1 + SC + 6);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_transitions pending=%0d required=0 next_cyc=%0d", q.size(), q[0].c);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
